// File: rtl/apb_int_servicer.sv
// apb_int_servicer: APB initiator that services an interrupt controller.
// It watches nLMINT, reads ISTAT, masks the highest-priority source through
// IENCLR, hands the vector to a consumer over VEC_VALID/VEC_READY, waits for
// SVC_DONE and then re-enables the source through IENSET.
// Optional build macro APB_SVC_SOFTCLR_EN: for soft vectors (0..3) the
// matching SOFTINT bit is cleared (IRSTAT read + SOFTINT write) before masking.
module apb_int_servicer #(
  parameter logic [1:0]  CPU_SEL = 2'b00,
  parameter int unsigned HOLDOFF = 3
) (
  input  logic       PCLK,
  input  logic       nRESET,
  input  logic       nLMINT,
  input  logic [7:0] PRDATA,
  output logic       PSEL,
  output logic       PENABLE,
  output logic       PWRITE,
  output logic [5:0] PADDR,
  output logic [7:0] PWDATA,
  output logic       VEC_VALID,
  output logic [2:0] VEC_ID,
  input  logic       VEC_READY,
  input  logic       SVC_DONE,
  output logic       BUSY
);

  localparam logic [3:0] REG_ISTAT   = 4'b0000;
  localparam logic [3:0] REG_IENSET  = 4'b0010;
  localparam logic [3:0] REG_IENCLR  = 4'b0011;
`ifdef APB_SVC_SOFTCLR_EN
  localparam logic [3:0] REG_IRSTAT  = 4'b0001;
  localparam logic [3:0] REG_SOFTINT = 4'b0100;
`endif

  localparam logic [2:0] HOLDOFF_LD = 3'(HOLDOFF);

  typedef enum logic [3:0] {
    S_IDLE,
    S_RD_ST,
    S_RD_AC,
    S_EVAL,
    S_CLR_ST,
    S_CLR_AC,
    S_PRESENT,
    S_WAIT_DONE,
    S_SET_ST,
    S_SET_AC
`ifdef APB_SVC_SOFTCLR_EN
    ,
    S_IRS_ST,
    S_IRS_AC,
    S_SFT_ST,
    S_SFT_AC
`endif
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] holdoff_q, holdoff_d;
  logic [7:0] stat_q, stat_d;
  logic [7:0] mask_q, mask_d;
  logic [2:0] vec_id_q, vec_id_d;
`ifdef APB_SVC_SOFTCLR_EN
  logic [3:0] raw_q, raw_d;
`endif

  logic       psel_q, psel_d;
  logic       penable_q, penable_d;
  logic       pwrite_q, pwrite_d;
  logic [5:0] paddr_q, paddr_d;
  logic [7:0] pwdata_q, pwdata_d;
  logic       vec_valid_q, vec_valid_d;
  logic       busy_q, busy_d;

  // Index of the highest set bit; bit 7 has the highest priority.
  function automatic logic [2:0] msb_index(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  // Sequencer: next state, holdoff countdown and the latched status/vector.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_d   = state_q;
    holdoff_d = holdoff_q;
    stat_d    = stat_q;
    mask_d    = mask_q;
    vec_id_d  = vec_id_q;
`ifdef APB_SVC_SOFTCLR_EN
    raw_d     = raw_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (holdoff_q != 3'd0) begin
          holdoff_d = holdoff_q - 3'd1;
        end else if (!nLMINT) begin
          state_d = S_RD_ST;
        end
      end
      S_RD_ST:  state_d = S_RD_AC;
      S_RD_AC: begin
        stat_d  = PRDATA;
        state_d = S_EVAL;
      end
      S_EVAL: begin
        if (stat_q == 8'h00) begin
          // Spurious request: nothing pending by the time ISTAT was read.
          holdoff_d = HOLDOFF_LD;
          state_d   = S_IDLE;
        end else begin
          vec_id_d = msb_index(stat_q);
          mask_d   = 8'h01 << vec_id_d;
`ifdef APB_SVC_SOFTCLR_EN
          state_d  = (vec_id_d[2] == 1'b0) ? S_IRS_ST : S_CLR_ST;
`else
          state_d  = S_CLR_ST;
`endif
        end
      end
`ifdef APB_SVC_SOFTCLR_EN
      S_IRS_ST: state_d = S_IRS_AC;
      S_IRS_AC: begin
        raw_d   = PRDATA[3:0];
        state_d = S_SFT_ST;
      end
      S_SFT_ST: state_d = S_SFT_AC;
      S_SFT_AC: state_d = S_CLR_ST;
`endif
      S_CLR_ST: state_d = S_CLR_AC;
      S_CLR_AC: state_d = S_PRESENT;
      S_PRESENT: begin
        // SVC_DONE is deliberately not looked at until the vector is accepted.
        if (VEC_READY) state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (SVC_DONE) state_d = S_SET_ST;
      end
      S_SET_ST: state_d = S_SET_AC;
      S_SET_AC: begin
        holdoff_d = HOLDOFF_LD;
        state_d   = S_IDLE;
      end
      default:  state_d = S_IDLE;
    endcase
  end

  // Output decode from the next state so every output is a flop aligned with its state.
  always_comb begin
    psel_d      = 1'b0;
    penable_d   = 1'b0;
    pwrite_d    = 1'b0;
    paddr_d     = 6'h00;
    pwdata_d    = 8'h00;
    vec_valid_d = (state_d == S_PRESENT);
    busy_d      = (state_d != S_IDLE);
    case (state_d)
      S_RD_ST, S_RD_AC: begin
        psel_d    = 1'b1;
        penable_d = (state_d == S_RD_AC);
        paddr_d   = {CPU_SEL, REG_ISTAT};
      end
      S_CLR_ST, S_CLR_AC: begin
        psel_d    = 1'b1;
        penable_d = (state_d == S_CLR_AC);
        pwrite_d  = 1'b1;
        paddr_d   = {CPU_SEL, REG_IENCLR};
        pwdata_d  = mask_d;
      end
      S_SET_ST, S_SET_AC: begin
        psel_d    = 1'b1;
        penable_d = (state_d == S_SET_AC);
        pwrite_d  = 1'b1;
        paddr_d   = {CPU_SEL, REG_IENSET};
        pwdata_d  = mask_d;
      end
`ifdef APB_SVC_SOFTCLR_EN
      S_IRS_ST, S_IRS_AC: begin
        psel_d    = 1'b1;
        penable_d = (state_d == S_IRS_AC);
        paddr_d   = {CPU_SEL, REG_IRSTAT};
      end
      S_SFT_ST, S_SFT_AC: begin
        psel_d    = 1'b1;
        penable_d = (state_d == S_SFT_AC);
        pwrite_d  = 1'b1;
        paddr_d   = {CPU_SEL, REG_SOFTINT};
        pwdata_d  = {4'b0000, raw_d & ~mask_d[3:0]};
      end
`endif
      default: ;
    endcase
  end

  // State and registered outputs; reset aborts any transfer in flight.
  always_ff @(posedge PCLK or negedge nRESET) begin
    if (!nRESET) begin
      state_q     <= S_IDLE;
      holdoff_q   <= 3'd0;
      stat_q      <= 8'h00;
      mask_q      <= 8'h00;
      vec_id_q    <= 3'd0;
`ifdef APB_SVC_SOFTCLR_EN
      raw_q       <= 4'h0;
`endif
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= 6'h00;
      pwdata_q    <= 8'h00;
      vec_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      holdoff_q   <= holdoff_d;
      stat_q      <= stat_d;
      mask_q      <= mask_d;
      vec_id_q    <= vec_id_d;
`ifdef APB_SVC_SOFTCLR_EN
      raw_q       <= raw_d;
`endif
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      vec_valid_q <= vec_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign VEC_VALID = vec_valid_q;
  assign VEC_ID    = vec_id_q;
  assign BUSY      = busy_q;

endmodule
